// File: rtl/decode_pipe.sv
// -----------------------------------------------------------------------------
// decode_pipe
//   Decode stage for the 16-bit ISA. It holds the register file (with an
//   optional same-cycle write-back bypass) and decodes the RS/RT/RD fields.
//   It also builds the Imm5/Imm8/sImm8/sImm11 immediates, extended to DATA_W.
//   Everything is registered into the ID/EX pipeline register, which has
//   load-use hazard detection, a downstream stall and a flush.
//
// Parameters
//   DATA_W   : datapath / register width (>= 16)
//   NUM_REGS : number of architectural registers (<= 8)
//   BYPASS   : 1 = write-back data forwarded to the read ports in the same cycle
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid, instr, pc_next IF/ID contents
//   regdst, reg_wrt, mem_rd,
//   zero_ext, rs_used,
//   rt_used                  control bits from the control unit
//   wb_en, wb_sel, wb_data   register-file write-back port
//   stall_in, flush          downstream stall, branch/jump redirect
//   id_stall                 IF/ID must hold (combinational)
//   ex_*                     ID/EX pipeline register contents
//   err                      sticky out-of-range register index flag
// -----------------------------------------------------------------------------
module decode_pipe #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] pc_next,
  input  logic [1:0]        regdst,
  input  logic              reg_wrt,
  input  logic              mem_rd,
  input  logic              zero_ext,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              wb_en,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              stall_in,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm5,
  output logic [DATA_W-1:0] ex_imm8,
  output logic [DATA_W-1:0] ex_simm8,
  output logic [DATA_W-1:0] ex_simm11,
  output logic [DATA_W-1:0] ex_pc,
  output logic [2:0]        ex_rd,
  output logic              ex_reg_wrt,
  output logic              ex_mem_rd,
  output logic              err
);

  localparam logic [3:0] NR = 4'(NUM_REGS);

  function automatic logic in_range(input logic [2:0] idx);
    return {1'b0, idx} < NR;
  endfunction

  // ---------------------------------------------------------------------------
  // Field decode
  // ---------------------------------------------------------------------------
  logic [2:0] rs_idx, rt_idx, rd_idx;

  assign rs_idx = instr[10:8];
  assign rt_idx = instr[7:5];

  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    rd_idx = instr[7:5];
    case (regdst)
      2'b01:   rd_idx = instr[10:8];
      2'b10:   rd_idx = instr[4:2];
      2'b11:   rd_idx = 3'd7;
      default: rd_idx = instr[7:5];
    endcase
  end

  // The opcode field is decoded by the control unit, not here.
  logic unused_opcode;
  assign unused_opcode = ^instr[15:11];

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;

  assign wr_en = wb_en & in_range(wb_sel);

  // NOTE: the register file is cleared by reset like every other state
  // element; there is no hard-wired zero register, so R0 is written normally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wb_sel == 3'(i)) regs[i] <= wb_data;
    end
  end

  // Read ports: indices beyond NUM_REGS match no entry and read as 0.
  logic [DATA_W-1:0] rs_data, rt_data;

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rs_idx == 3'(i)) rs_data = regs[i];
      if (rt_idx == 3'(i)) rt_data = regs[i];
    end
    if (BYPASS != 0 && wr_en) begin
      if (rs_idx == wb_sel) rs_data = wb_data;
      if (rt_idx == wb_sel) rt_data = wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Immediates
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] imm5, imm8, simm8, simm11;

  assign imm5   = zero_ext ? {{(DATA_W-5){1'b0}}, instr[4:0]}
                           : {{(DATA_W-5){instr[4]}}, instr[4:0]};
  assign simm8  = {{(DATA_W-8){instr[7]}}, instr[7:0]};
  assign imm8   = zero_ext ? {{(DATA_W-8){1'b0}}, instr[7:0]} : simm8;
  assign simm11 = {{(DATA_W-11){instr[10]}}, instr[10:0]};

  // ---------------------------------------------------------------------------
  // Hazard detection: a load in EX whose destination is read by the
  // instruction in ID costs exactly one bubble; once the bubble is in EX
  // ex_valid is 0 and the stall releases on its own.
  // ---------------------------------------------------------------------------
  logic hz;

  assign hz = ex_valid & ex_mem_rd & in_valid &
              ((rs_used & (ex_rd == rs_idx)) | (rt_used & (ex_rd == rt_idx)));
  assign id_stall = hz | stall_in;

  logic err_set;

  assign err_set = (wb_en & ~in_range(wb_sel)) |
                   (in_valid & ((rs_used & ~in_range(rs_idx)) |
                                (rt_used & ~in_range(rt_idx)) |
                                ~in_range(rd_idx)));

  // ---------------------------------------------------------------------------
  // ID/EX register. Priority: flush > stall_in > hazard bubble > capture.
  // Fields not listed under flush/bubble simply hold, which keeps them
  // deterministic.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid   <= 1'b0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm5    <= '0;
      ex_imm8    <= '0;
      ex_simm8   <= '0;
      ex_simm11  <= '0;
      ex_pc      <= '0;
      ex_rd      <= '0;
      ex_reg_wrt <= 1'b0;
      ex_mem_rd  <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (err_set) err <= 1'b1;

      if (flush || (!stall_in && hz)) begin
        ex_valid   <= 1'b0;
        ex_reg_wrt <= 1'b0;
        ex_mem_rd  <= 1'b0;
      end else if (!stall_in) begin
        ex_valid   <= in_valid;
        ex_rs_data <= rs_data;
        ex_rt_data <= rt_data;
        ex_imm5    <= imm5;
        ex_imm8    <= imm8;
        ex_simm8   <= simm8;
        ex_simm11  <= simm11;
        ex_pc      <= pc_next;
        ex_rd      <= rd_idx;
        ex_reg_wrt <= reg_wrt & in_valid;
        ex_mem_rd  <= mem_rd & in_valid;
      end
    end
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised successor to the single-cycle decode stage for the 16-bit ISA.
- Holds the register file with an optional write-back bypass and decodes the RS, RT and RD fields.
- Generates the Imm5, Imm8, sImm8 and sImm11 immediates, extended to DATA_W.
- Registers all results into an ID/EX pipeline register, with load-use hazard detection, a downstream stall and a flush.
- Sits between the IF/ID register and the execute stage; the control unit supplies the decoded control bits.

Parameters:
- DATA_W, 16: datapath and register width; must be >= 16.
- NUM_REGS, 8: number of architectural registers; must be <= 8 (3-bit register fields).
- BYPASS, 1: 1 = same-cycle write-back data is forwarded to the read ports; 0 = plain read.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  IF/ID holds a valid instruction.
- instr  in  16  instruction.
- pc_next  in  DATA_W  PC+2 of the instruction.
- regdst  in  2  destination select: 00 = instr[7:5], 01 = instr[10:8], 10 = instr[4:2], 11 = R7.
- reg_wrt  in  1  instruction writes a register.
- mem_rd  in  1  instruction is a load.
- zero_ext  in  1  zero-extend Imm5 and Imm8 instead of sign-extending.
- rs_used, rt_used  in  1 each  instruction reads RS (instr[10:8]) / RT (instr[7:5]).
- wb_en  in  1  write-back enable.
- wb_sel  in  3  write-back register index.
- wb_data  in  DATA_W  write-back data.
- stall_in  in  1  downstream stall; ID/EX holds.
- flush  in  1  branch/jump redirect; kills ID/EX contents.
- id_stall  out  1  IF/ID must hold (combinational).
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_rs_data, ex_rt_data  out  DATA_W  register operands.
- ex_imm5, ex_imm8, ex_simm8, ex_simm11  out  DATA_W  extended immediates.
- ex_pc  out  DATA_W  registered pc_next.
- ex_rd  out  3  destination register index.
- ex_reg_wrt, ex_mem_rd  out  1 each  registered control bits.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers clear to 0.
  - All ex_* outputs clear to 0; err clears to 0.
  - Reset mid-operation discards any in-flight instruction; no register write happens on that edge.
- Register file:
  - Write on the rising edge when wb_en=1 and wb_sel < NUM_REGS.
  - Reads are combinational.
  - BYPASS=1: a read index equal to wb_sel with wb_en=1 returns wb_data in the same cycle.
  - BYPASS=0: that read returns the old value.
- Immediates:
  - Imm5 = instr[4:0], zero- or sign-extended (bit 4) to DATA_W according to zero_ext.
  - sImm8 = instr[7:0] sign-extended (bit 7).
  - Imm8 = zero-extended when zero_ext=1, else equal to sImm8.
  - sImm11 = instr[10:0] sign-extended (bit 10).
- Hazard:
  - hz = ex_valid & ex_mem_rd & in_valid & ((rs_used & ex_rd==instr[10:8]) | (rt_used & ex_rd==instr[7:5])).
  - id_stall = hz | stall_in.
- ID/EX update priority on each rising edge:
  1. flush: ex_valid, ex_reg_wrt and ex_mem_rd go to 0; the other fields are don't-care but must be deterministic. Flush overrides stall_in and hz.
  2. stall_in: all ex_* hold.
  3. hz: insert a bubble (ex_valid, ex_reg_wrt, ex_mem_rd = 0). The instruction stays in IF/ID and is re-decoded next cycle; one bubble per load-use.
  4. Otherwise capture:
     - ex_valid = in_valid, ex_rd = decoded RD.
     - ex_reg_wrt = reg_wrt & in_valid; ex_mem_rd = mem_rd & in_valid.
     - Operands (bypassed when BYPASS=1), immediates and pc_next.
- Latency: one cycle from IF/ID to ID/EX.
- err:
  - Set on a rising edge when wb_en with wb_sel >= NUM_REGS.
  - Set on a rising edge when in_valid with a used RS/RT or the decoded RD >= NUM_REGS.
  - Cleared only by reset.
  - An out-of-range read returns 0.
- A write-back to R0 is permitted; there is no hard-wired zero register.

Test Plan:
- Reset, then write R3=0x1234 via wb; next cycle instr=0x4B60 with rs_used=1 → ex_rs_data=0x1234 one cycle later, ex_valid=1.
- BYPASS=1: wb_en, wb_sel=2, wb_data=0xBEEF in the same cycle as a decode reading RT=R2 → ex_rt_data=0xBEEF. BYPASS=0: same stimulus → old R2 value.
- Load to R4 in EX (ex_mem_rd=1, ex_rd=4), next instr reads RS=R4 → id_stall=1 for exactly 1 cycle, one bubble (ex_valid=0), then the instruction issues with ex_valid=1.
- instr[10:0]=0x400, zero_ext=0 → ex_simm11=0xFC00. instr[4:0]=0x10 with zero_ext=1 → ex_imm5=0x0010; with zero_ext=0 → 0xFFF0.
- flush together with stall_in and hz → ex_valid=0 next cycle. stall_in alone for 3 cycles → all ex_* unchanged.
- NUM_REGS=4, wb_sel=6 with wb_en → err=1 and stays 1. Assert rst=0 mid-stream → err and all ex_* are 0 immediately, without a clock edge.
